// File: rtl/g06_sha256_sequencer.sv
// Avalon-MM controlled sequencer for the g06 SHA-256 compression datapath:
// message loading, IV/working-register load, 64 rounds and hash accumulation.
module g06_sha256_sequencer #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        msg_wr_en,
  output logic [3:0]  msg_wr_idx,
  output logic [31:0] msg_wr_data,
  output logic        dp_init_h,
  output logic        dp_load_work,
  output logic        dp_round_en,
  output logic [5:0]  dp_round_idx,
  output logic        dp_accum,
  output logic [2:0]  dp_hash_sel,
  input  logic [31:0] dp_hash_word,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a CTRL start/init write; MSG writes accepted
  // IV    | one-cycle pulse loading H0..H7 with the SHA-256 IV
  // LOAD  | one-cycle pulse copying H0..H7 into a..h
  // ROUND | one compression round per cycle, idx 0..ROUNDS-1
  // ACCUM | one-cycle pulse adding a..h into H0..H7
  typedef enum logic [2:0] {IDLE, IV, LOAD, ROUND, ACCUM} state_t;

  state_t           state, state_nxt;
  logic [5:0]       round_cnt;
  logic             start_pend;
  logic             done, err;
  logic [CNT_W-1:0] block_count;
  logic             idle, ctrl_wr, cmd_go, msg_wr, err_set;

  assign idle        = (state == IDLE);
  assign busy        = !idle;
  assign ctrl_wr     = avs_write && (avs_address == 5'd0);
  assign cmd_go      = ctrl_wr && (avs_writedata[0] || avs_writedata[1]);
  assign msg_wr      = avs_write && avs_address[4];
  assign err_set     = !idle && (cmd_go || msg_wr);
  assign dp_hash_sel = avs_address[2:0];

  always_comb begin
    state_nxt    = state;
    dp_init_h    = 1'b0;
    dp_load_work = 1'b0;
    dp_round_en  = 1'b0;
    dp_round_idx = 6'd0;
    dp_accum     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_go) state_nxt = avs_writedata[1] ? IV : LOAD;
      end
      IV: begin
        dp_init_h = 1'b1;
        state_nxt = start_pend ? LOAD : IDLE;
      end
      LOAD: begin
        dp_load_work = 1'b1;
        state_nxt    = ROUND;
      end
      ROUND: begin
        dp_round_en  = 1'b1;
        dp_round_idx = round_cnt;
        if (round_cnt == 6'(ROUNDS - 1)) state_nxt = ACCUM;
      end
      ACCUM: begin
        dp_accum  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= IDLE;
      round_cnt   <= 6'd0;
      start_pend  <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      block_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD)       round_cnt <= 6'd0;
      else if (state == ROUND) round_cnt <= round_cnt + 6'd1;
      if (idle && cmd_go) start_pend <= avs_writedata[0];
      if (state == IV)         block_count <= '0;
      else if (state == ACCUM) block_count <= block_count + 1'b1;
      if (state == ACCUM)       done <= 1'b1;
      else if (idle && cmd_go)  done <= 1'b0;
      // a rejected command in the same cycle as a clear leaves err set
      if (err_set)                         err <= 1'b1;
      else if (ctrl_wr && avs_writedata[2]) err <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      msg_wr_en   <= 1'b0;
      msg_wr_idx  <= 4'd0;
      msg_wr_data <= 32'd0;
    end else begin
      msg_wr_en <= msg_wr && idle;
      if (msg_wr && idle) begin
        msg_wr_idx  <= avs_address[3:0];
        msg_wr_data <= avs_writedata;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      if (avs_address == 5'd0)           avs_readdata <= {29'd0, err, done, busy};
      else if (avs_address == 5'd1)      avs_readdata <= 32'(block_count);
      else if (avs_address[4:3] == 2'b01) avs_readdata <= dp_hash_word;
      else                               avs_readdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_g06_sha256_sequencer.sv
// Scoreboard bench for g06_sha256_sequencer with a behavioural SHA-256 datapath.
module tb_g06_sha256_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        msg_wr_en;
  logic [3:0]  msg_wr_idx;
  logic [31:0] msg_wr_data;
  logic        dp_init_h, dp_load_work, dp_round_en, dp_accum;
  logic [5:0]  dp_round_idx;
  logic [2:0]  dp_hash_sel;
  logic [31:0] dp_hash_word;
  logic        busy;

  always #5 clk = ~clk;

  g06_sha256_sequencer #(.ROUNDS(64), .CNT_W(16)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata),
    .msg_wr_en(msg_wr_en), .msg_wr_idx(msg_wr_idx), .msg_wr_data(msg_wr_data),
    .dp_init_h(dp_init_h), .dp_load_work(dp_load_work), .dp_round_en(dp_round_en),
    .dp_round_idx(dp_round_idx), .dp_accum(dp_accum), .dp_hash_sel(dp_hash_sel),
    .dp_hash_word(dp_hash_word), .busy(busy)
  );

  // reference datapath
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] H_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] H_ABC [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  logic [31:0] hm [8];
  logic [31:0] wk [8];
  logic [31:0] wbuf [16];
  logic [31:0] wsch [64];
  logic [31:0] t1, t2, s0, s1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  assign dp_hash_word = hm[dp_hash_sel];

  always @(posedge clk) begin
    if (msg_wr_en) wbuf[msg_wr_idx] = msg_wr_data;
    if (dp_init_h) for (int i = 0; i < 8; i++) hm[i] <= H_IV[i];
    if (dp_load_work) begin
      for (int i = 0; i < 8; i++) wk[i] = hm[i];
      for (int t = 0; t < 64; t++) begin
        if (t < 16) wsch[t] = wbuf[t];
        else begin
          s0 = rotr(wsch[t-15], 7) ^ rotr(wsch[t-15], 18) ^ (wsch[t-15] >> 3);
          s1 = rotr(wsch[t-2], 17) ^ rotr(wsch[t-2], 19) ^ (wsch[t-2] >> 10);
          wsch[t] = wsch[t-16] + s0 + wsch[t-7] + s1;
        end
      end
    end
    if (dp_round_en) begin
      t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
         + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[dp_round_idx] + wsch[dp_round_idx];
      t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
         + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
      for (int i = 7; i > 0; i--) wk[i] = wk[i-1];
      wk[4] = wk[4] + t1;
      wk[0] = t1 + t2;
    end
    if (dp_accum) for (int i = 0; i < 8; i++) hm[i] <= hm[i] + wk[i];
  end

  // scoreboard
  typedef struct packed {
    logic       busy, ini, ld, ren;
    logic [5:0] idx;
    logic       acc;
  } strobe_t;
  typedef struct {
    string       nm;
    logic [31:0] v;
  } rd_exp_t;
  typedef struct {
    string       nm;
    logic [31:0] act, exp;
  } dir_t;

  strobe_t     sq [$];
  rd_exp_t     rq [$];
  logic [35:0] mq [$];
  dir_t        dq [$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic        rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= avs_read;

  always @(negedge clk) begin
    strobe_t act, e;
    rd_exp_t r;
    dir_t d;
    logic [35:0] m;
    act = '{busy, dp_init_h, dp_load_work, dp_round_en, dp_round_idx, dp_accum};
    if (sq.size() > 0) begin
      e = sq.pop_front();
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL strobes t=%0t got %h want %h", $time, act, e);
      end
    end
    if (msg_wr_en) begin
      n_chk++;
      if (mq.size() == 0) begin
        n_fail++;
        $display("FAIL msg_wr unexpected idx=%0d data=%h want no pulse", msg_wr_idx, msg_wr_data);
      end else begin
        m = mq.pop_front();
        if ({msg_wr_idx, msg_wr_data} !== m) begin
          n_fail++;
          $display("FAIL msg_wr got %h want %h", {msg_wr_idx, msg_wr_data}, m);
        end
      end
    end
    if (rd_seen && rq.size() > 0) begin
      r = rq.pop_front();
      n_chk++;
      if (avs_readdata !== r.v) begin
        n_fail++;
        $display("FAIL read %s got %h want %h", r.nm, avs_readdata, r.v);
      end
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      n_chk++;
      if (d.act !== d.exp) begin
        n_fail++;
        $display("FAIL %s got %h want %h", d.nm, d.act, d.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] v, input string nm);
    avs_address = a; avs_read = 1'b1;
    rq.push_back('{nm, v});
    cyc();
    avs_read = 1'b0;
  endtask

  task automatic push_st(input logic b, input logic i, input logic l, input logic r,
                         input logic [5:0] x, input logic a);
    sq.push_back('{b, i, l, r, x, a});
  endtask

  // expected strobes from the write cycle T through the return to IDLE
  task automatic push_seq(input bit with_iv, input int n_rounds, input bit finish);
    push_st(0, 0, 0, 0, 0, 0);
    if (with_iv) push_st(1, 1, 0, 0, 0, 0);
    push_st(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < n_rounds; i++) push_st(1, 0, 0, 1, 6'(i), 0);
    if (finish) begin
      push_st(1, 0, 0, 0, 0, 1);
      push_st(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sq.size() > 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    dq.push_back('{nm, 32'(sq.size()), 32'd0});
    sq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] msg [16];
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;

    cyc(); cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    bus_read(5'd0, 32'd0, "reset_status");
    bus_read(5'd1, 32'd0, "reset_count");
    bus_read(5'd3, 32'd0, "addr3");

    // load "abc" block, then init+start
    for (int i = 0; i < 16; i++) begin
      mq.push_back({4'(i), msg[i]});
      bus_write(5'(16 + i), msg[i]);
    end
    push_seq(1, 64, 1);
    bus_write(5'd0, 32'h3);
    drain("drain_abc");
    cyc();
    bus_read(5'd0, 32'h2, "status_done");
    bus_read(5'd1, 32'd1, "count_one");
    for (int i = 0; i < 8; i++) bus_read(5'(8 + i), H_ABC[i], "hash_abc");
    avs_address = 5'd9; avs_read = 1'b1;
    rq.push_back('{"addr9_model", hm[1]});
    dq.push_back('{"hash_sel", 32'(dp_hash_sel), 32'd1});
    cyc();
    avs_read = 1'b0;

    // reset asserted while ROUND is at idx 30
    push_seq(0, 31, 0);
    bus_write(5'd0, 32'h1);
    drain("drain_to_idx30");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) push_st(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    drain("drain_reset");
    cyc();
    bus_read(5'd0, 32'd0, "status_after_rst");
    bus_read(5'd1, 32'd0, "count_after_rst");

    // commands while busy are rejected and flag err
    push_seq(0, 64, 1);
    bus_write(5'd0, 32'h1);
    repeat (10) cyc();
    bus_write(5'd0, 32'h1);
    bus_write(5'd20, 32'hdeadbeef);
    drain("drain_busy");
    cyc();
    bus_read(5'd0, 32'h6, "status_err");
    avs_address = 5'd0; avs_writedata = 32'h4; avs_write = 1'b1; avs_read = 1'b1;
    rq.push_back('{"status_rw_pre", 32'h6});
    cyc();
    avs_write = 1'b0; avs_read = 1'b0;
    bus_read(5'd0, 32'h2, "status_err_clr");
    bus_read(5'd1, 32'd1, "count_busy_blk");

    // block counter wrap
    force dut.block_count = 16'hffff;
    cyc();
    release dut.block_count;
    bus_read(5'd1, 32'h0000ffff, "count_preload");
    push_seq(0, 64, 1);
    bus_write(5'd0, 32'h1);
    drain("drain_wrap");
    cyc();
    bus_read(5'd1, 32'd0, "count_wrap");
    bus_read(5'd0, 32'h2, "status_wrap");

    // init_h only: IV then back to IDLE
    push_st(0, 0, 0, 0, 0, 0);
    push_st(1, 1, 0, 0, 0, 0);
    push_st(0, 0, 0, 0, 0, 0);
    bus_write(5'd0, 32'h2);
    drain("drain_init");
    cyc();
    bus_read(5'd0, 32'd0, "status_init");
    bus_read(5'd1, 32'd0, "count_init");
    bus_read(5'd8, H_IV[0], "hash_iv0");

    cyc(); cyc();
    dq.push_back('{"rd_queue_empty", 32'(rq.size()), 32'd0});
    dq.push_back('{"msg_queue_empty", 32'(mq.size()), 32'd0});
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
